// File: rtl/regfile_mp_sb.sv
// Multi-read-port integer register file with a pending-write scoreboard and a sequenced clear after reset.
// Optional write-through bypass on every read port is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp_sb #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_pending,
  output logic                init_busy,
  output logic [2**AW-1:0]    pend_vec
);

  localparam int NREGS = 2**AW;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NREGS - 1);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] pend_q, pend_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             initBusy_q, initBusy_d;
  logic             wrFire, rsvFire;

  assign wrFire  = wr_en  && !initBusy_q && (wr_addr  != '0);
  assign rsvFire = rsv_en && !initBusy_q && (rsv_addr != '0);

  // Clear sequencer and scoreboard next state; a reserve on the same edge as a write wins
  always_comb begin
    cnt_d      = cnt_q;
    initBusy_d = initBusy_q;
    pend_d     = pend_q;
    if (initBusy_q) begin
      if (cnt_q == LAST_ADDR) begin
        initBusy_d = 1'b0;
      end else begin
        cnt_d = cnt_q + AW'(1);
      end
    end
    if (wrFire) begin
      pend_d[wr_addr] = 1'b0;
    end
    if (rsvFire) begin
      pend_d[rsv_addr] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= AW'(1);
      initBusy_q <= 1'b1;
      pend_q     <= '0;
    end else begin
      cnt_q      <= cnt_d;
      initBusy_q <= initBusy_d;
      pend_q     <= pend_d;
    end
  end

  // Register storage is cleared by the sequencer rather than by reset; entry 0 is never written
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (initBusy_q) begin
        regs_q[cnt_q] <= '0;
      end else if (wrFire) begin
        regs_q[wr_addr] <= wr_data;
      end
    end
  end

  always_comb begin
    rd_data    = '0;
    rd_pending = '0;
    for (int i = 0; i < NRD; i++) begin
      logic [AW-1:0] addr;
      addr = rd_addr[i*AW +: AW];
      if (!initBusy_q && (addr != '0)) begin
        rd_data[i*XLEN +: XLEN] = regs_q[addr];
        rd_pending[i]           = pend_q[addr];
`ifdef REGFILE_BYPASS_EN
        if (wrFire && (wr_addr == addr)) begin
          rd_data[i*XLEN +: XLEN] = wr_data;
          rd_pending[i]           = 1'b0;
        end
`endif
      end
    end
  end

  assign init_busy = initBusy_q;
  assign pend_vec  = pend_q;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed testbench for regfile_mp_sb with default parameters (XLEN=32, AW=5, NRD=2).
// Expectations follow the build: REGFILE_BYPASS_EN selects the same-cycle bypass results.
module tb_regfile_mp_sb;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_pending;
  logic        init_busy;
  logic [31:0] pend_vec;

  int assertCount = 0;
  int failCount   = 0;
  int cycles;

  regfile_mp_sb #(.XLEN(32), .AW(5), .NRD(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rsv_en     (rsv_en),
    .rsv_addr   (rsv_addr),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_pending (rd_pending),
    .init_busy  (init_busy),
    .pend_vec   (pend_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic re, input logic [4:0] ra,
                               input logic [4:0] r0, input logic [4:0] r1);
    wr_en    = we;
    wr_addr  = wa;
    wr_data  = wd;
    rsv_en   = re;
    rsv_addr = ra;
    rd_addr  = {r1, r0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until init_busy drops, bounded so a stuck sequencer still reaches the summary
  task automatic countInit(output int n);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      n++;
      if (!init_busy) break;
    end
  endtask

  initial begin
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    reset = 1'b1;
    tick();
    tick();
    checkOutput("reset_busy", {63'h0, init_busy}, 64'h1);
    checkOutput("reset_pend", {32'h0, pend_vec}, 64'h0);

    // Writes and reserves offered throughout the clear must be ignored
    applyStimulus(1'b1, 5'd4, 32'hFFFF_FFFF, 1'b1, 5'd6, 5'd4, 5'd6);
    reset = 1'b0;
    #2;
    checkOutput("init_rd_data", rd_data, 64'h0);
    checkOutput("init_rd_pend", {62'h0, rd_pending}, 64'h0);
    countInit(cycles);
    checkOutput("init_cycles", 64'(cycles), 64'd31);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    #1;
    checkOutput("init_pend_ignored", {32'h0, pend_vec}, 64'h0);
    for (int r = 1; r < 32; r++) begin
      rd_addr = {5'd0, 5'(r)};
      #1;
      checkOutput($sformatf("clear_x%0d", r), {32'h0, rd_data[31:0]}, 64'h0);
    end

    // Restart mid-sequence: 9 edges after release the counter holds 10
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    checkOutput("mid_busy", {63'h0, init_busy}, 64'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("restart_busy", {63'h0, init_busy}, 64'h1);
    countInit(cycles);
    checkOutput("restart_cycles", 64'(cycles), 64'd31);

    applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0);
    #1;
    checkOutput("x5_port0", {32'h0, rd_data[31:0]}, 64'hDEAD_BEEF);
    checkOutput("x0_port1", {32'h0, rd_data[63:32]}, 64'h0);

    applyStimulus(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 5'd0, 5'd5);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd5);
    #1;
    checkOutput("x0_write_dropped", {32'h0, rd_data[31:0]}, 64'h0);
    checkOutput("x0_pend_vec", {32'h0, pend_vec}, 64'h0);
    checkOutput("x5_port1", {32'h0, rd_data[63:32]}, 64'hDEAD_BEEF);

    // Reserve x7 while reading it: that read still sees not-pending
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd0);
    #1;
    checkOutput("x7_rsv_same_cycle", {62'h0, rd_pending}, 64'h0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0);
    #1;
    checkOutput("x7_pending", {62'h0, rd_pending}, 64'h1);
    checkOutput("x7_pend_vec", {32'h0, pend_vec}, 64'h80);
    applyStimulus(1'b1, 5'd7, 32'h55, 1'b0, 5'd0, 5'd7, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0);
    #1;
    checkOutput("x7_cleared", {62'h0, rd_pending}, 64'h0);
    checkOutput("x7_data", {32'h0, rd_data[31:0]}, 64'h55);

    applyStimulus(1'b1, 5'd9, 32'hAA, 1'b1, 5'd9, 5'd0, 5'd9);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd9);
    #1;
    checkOutput("x9_pend_vec", {32'h0, pend_vec}, 64'h200);
    checkOutput("x9_data", {32'h0, rd_data[63:32]}, 64'hAA);
    checkOutput("x9_pending_p1", {62'h0, rd_pending}, 64'h2);

    // Write to a non-pending register leaves its bit clear
    applyStimulus(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 5'd3, 5'd3);
    tick();
    checkOutput("x3_nonpend_write", {32'h0, pend_vec}, 64'h200);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd3);
    tick();
    applyStimulus(1'b1, 5'd3, 32'h77, 1'b0, 5'd0, 5'd3, 5'd3);
    #1;
`ifdef REGFILE_BYPASS_EN
    checkOutput("x3_bypass_data", rd_data, 64'h0000_0077_0000_0077);
    checkOutput("x3_bypass_pend", {62'h0, rd_pending}, 64'h0);
`else
    checkOutput("x3_old_data", rd_data, 64'h0000_0011_0000_0011);
    checkOutput("x3_old_pend", {62'h0, rd_pending}, 64'h3);
`endif
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3);
    #1;
    checkOutput("x3_next_data", rd_data, 64'h0000_0077_0000_0077);
    checkOutput("x3_next_pend", {62'h0, rd_pending}, 64'h0);
    checkOutput("final_pend_vec", {32'h0, pend_vec}, 64'h200);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
Parametrised multi-read-port integer register file with an integrated pending-write scoreboard. It is intended for the pipelined successor of the single-cycle RISC-V core.
- Decode reads operands and reserves the destination register on the same file.
- Writeback writes results and clears the reservation.
- Reset runs a sequenced clear of all registers instead of loading preset values.

Parameters:
XLEN, 32, data width of each register
AW, 5, register address width; NREGS = 2**AW (AW >= 1)
NRD, 2, number of read ports (>= 1)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high
wr_en  input  1  write strobe (writeback)
wr_addr  input  AW  write address
wr_data  input  XLEN  write data
rsv_en  input  1  reserve destination (issue)
rsv_addr  input  AW  register to mark pending
rd_addr  input  NRD*AW  packed read addresses, port i at [i*AW +: AW]
rd_data  output  NRD*XLEN  packed combinational read data, port i at [i*XLEN +: XLEN]
rd_pending  output  NRD  per-port: operand not yet written back
init_busy  output  1  clear sequence in progress
pend_vec  output  NREGS  raw scoreboard bits, bit 0 always 0

Behaviour:
- Interface: reset is synchronous and active-high; the clock is clk.
- Reset behaviour:
  - While reset is high: init_busy=1, clear counter=1, all pend bits=0.
  - After reset falls, the clear sequence writes 0 to register cnt each cycle, cnt = 1 .. NREGS-1.
  - init_busy falls on the edge after cnt=NREGS-1 is written, i.e. NREGS-1 cycles after reset deasserts (31 for the defaults).
  - Reset asserted mid-sequence restarts the sequence at cnt=1.
- During init_busy:
  - wr_en and rsv_en are ignored.
  - All rd_data = 0.
  - All rd_pending = 0.
- Register x0:
  - Never stored and never reserved.
  - Reads always return 0.
  - Writes and reserves to address 0 are dropped.
  - pend_vec[0] = 0.
- Write: on a rising edge with wr_en=1, !init_busy and wr_addr!=0, set reg[wr_addr] <= wr_data and clear pend[wr_addr].
- Reserve: on a rising edge with rsv_en=1, !init_busy and rsv_addr!=0, set pend[rsv_addr] <= 1.
- Same-edge write and reserve to the same address: data is written and the pend bit ends at 1 (reserve wins; a newer producer owns the register).
- Write to a non-pending register is legal: data is written and the pend bit stays 0.
- Read, per port i, combinational with zero latency:
  - rd_addr=0 gives rd_data=0 and rd_pending=0.
  - Otherwise rd_data = reg[rd_addr] and rd_pending = pend[rd_addr], subject to the bypass rules under Optional Feature.
- All NRD ports are independent. Any number of ports may read the same address.
- A reserve issued in the same cycle as a read of that address does not affect that read's rd_pending; the bit becomes visible next cycle.
- Width rules:
  - No arithmetic on data.
  - Address compares use full AW bits.
  - The clear counter is AW bits wide and does not wrap: it stops at NREGS-1.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: write-through bypass on every read port. When wr_en=1, !init_busy, wr_addr!=0 and wr_addr==rd_addr[i]:
  - rd_data[i] = wr_data in the same cycle.
  - rd_pending[i] = 0 in the same cycle.
- Undefined:
  - Reads return the stored value, which updates the cycle after the write edge.
  - rd_pending reflects pend bits only.
  - Decode must stall one extra cycle.

Test Plan:
- Pulse reset 2 cycles, then release -> init_busy=1 for exactly 31 cycles then 0; afterwards reading every register 1..31 on port 0 returns 0.
- Assert reset at cnt=10 for 1 cycle -> sequence restarts, init_busy drops 31 cycles after the new release.
- After init: write x5=0xDEADBEEF, next cycle read port0=x5 and port1=x0 -> rd_data 0xDEADBEEF / 0x0; write to x0 with 0x1234 -> x0 still reads 0.
- Reserve x7, next cycle read x7 -> rd_pending=1, pend_vec[7]=1. Write x7=0x55 -> next cycle rd_pending=0, rd_data=0x55.
- Same edge: reserve x9 and write x9=0xAA -> pend_vec[9]=1, reg x9 reads 0xAA.
- With REGFILE_BYPASS_EN, x3 pending, write x3=0x77 while reading x3 on both ports -> same cycle rd_data=0x77 and rd_pending=0 on both. Without the macro -> old value and rd_pending=1 that cycle, 0x77 and rd_pending=0 the next cycle.
